// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Build option MDU_EARLY_OUT_EN: a multiply finishes once its remaining multiplier bits are zero.
`timescale 1ns/1ps
module mdu_iter #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_in,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);

  // Handshake: a request is taken on a rising edge where ready=1, valid_in=1, flush=0 and op<=9;
  // done is a one-cycle pulse with no backpressure, and result holds until the next done.

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_MUL = 4'd0, OP_MULW = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3;
  localparam logic [3:0] OP_REM = 4'd4, OP_REMU = 4'd5, OP_DIVW = 4'd6, OP_DIVUW = 4'd7;
  localparam logic [3:0] OP_REMW = 4'd8, OP_REMUW = 4'd9;

  function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  acc_q, x_q, y_q, res_q, result_q;
  logic             is_mul_q, is_w_q, is_rem_q, neg_q_q, neg_r_q;
  logic             ready_r, busy_r, done_r;

  // request decode and operand preparation
  logic            in_mul, in_w, in_sgn, in_rem, legal;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_n, spec_res;
  logic            neg_a, neg_b, div0, ovf;

  always_comb begin
    in_mul = (op == OP_MUL) || (op == OP_MULW);
    in_w   = (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
             (op == OP_REMW) || (op == OP_REMUW);
    in_sgn = (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
    in_rem = (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
    legal  = (op <= OP_REMUW);
    if (in_w) begin
      a_ext = in_sgn ? {{(XLEN-32){a[31]}}, a[31:0]} : {{(XLEN-32){1'b0}}, a[31:0]};
      b_ext = in_sgn ? {{(XLEN-32){b[31]}}, b[31:0]} : {{(XLEN-32){1'b0}}, b[31:0]};
      min_n = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext = a;
      b_ext = b;
      min_n = {1'b1, {(XLEN-1){1'b0}}};
    end
    neg_a = in_sgn && a_ext[XLEN-1];
    neg_b = in_sgn && b_ext[XLEN-1];
    mag_a = neg_a ? -a_ext : a_ext;
    mag_b = neg_b ? -b_ext : b_ext;
    div0  = (b_ext == '0);
    ovf   = in_sgn && (a_ext == min_n) && (b_ext == '1);
    // division by zero and signed overflow never iterate
    if (div0) spec_res = sext_w(in_w, in_rem ? a_ext : '1);
    else      spec_res = sext_w(in_w, in_rem ? '0 : a_ext);
  end

  // one iteration step; acc/x/y are product/multiplicand/multiplier or remainder/divisor/quotient
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub, acc_n, x_n, y_n, quo_s, rem_s, fin;
  logic            ge, last;

  always_comb begin
    rem_sh  = {acc_q, y_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, x_q});
    rem_sub = rem_sh[XLEN-1:0] - x_q;
    if (is_mul_q) begin
      acc_n = y_q[0] ? (acc_q + x_q) : acc_q;
      x_n   = x_q << 1;
      y_n   = y_q >> 1;
    end else begin
      acc_n = ge ? rem_sub : rem_sh[XLEN-1:0];
      x_n   = x_q;
      y_n   = {y_q[XLEN-2:0], ge};
    end
    quo_s = neg_q_q ? -y_n : y_n;
    rem_s = neg_r_q ? -acc_n : acc_n;
    fin   = sext_w(is_w_q, is_mul_q ? acc_n : (is_rem_q ? rem_s : quo_s));
    last  = (cnt_q == CNT_W'(1));
`ifdef MDU_EARLY_OUT_EN
    if (is_mul_q && (y_n == '0)) last = 1'b1;
`else
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      is_mul_q <= 1'b0;
      is_w_q   <= 1'b0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && legal && !flush) begin
            is_mul_q <= in_mul;
            is_w_q   <= in_w;
            is_rem_q <= in_rem;
            neg_q_q  <= neg_a ^ neg_b;
            neg_r_q  <= neg_a;
            acc_q    <= '0;
            x_q      <= in_mul ? a_ext : mag_b;
            // a W dividend sits in the top half so its MSB leaves first
            y_q      <= in_mul ? b_ext : (in_w ? {mag_a[31:0], 32'b0} : mag_a);
            ready_r  <= 1'b0;
            if (!in_mul && (div0 || ovf)) begin
              res_q  <= spec_res;
              cnt_q  <= '0;
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              cnt_q  <= in_w ? CNT_W'(32) : CNT_W'(XLEN);
              state  <= CALC;
              busy_r <= 1'b1;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            acc_q <= acc_n;
            x_q   <= x_n;
            y_q   <= y_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) begin
              res_q  <= fin;
              cnt_q  <= '0;
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          // a flushed result is dropped and the previous result stays visible
          if (!flush) result_q <= res_q;
          state   <= IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_r;
  assign busy      = busy_r;
  assign done      = done_r && !flush;
  assign result    = done ? res_q : result_q;
  assign state_dbg = state;

endmodule
